to_upper: RTL and testbench
===========================

// Module: to_upper
// PURPOSE
//   Streaming ASCII case converter: maps each lowercase letter 'a'..'z'
//   (0x61..0x7A) to its uppercase form and passes every other byte through
//   unchanged, including control codes, DEL and all bytes 0x80..0xFF.
//   Sits in the byte datapath between a character source and sink.
//   Uses a valid/ready handshake with a one-deep output register, and keeps
//   a saturating count of the bytes it converted.
// PARAMETERS
//   COUNT_W   16   width of the conv_count statistic counter
// PORTS
//   clk            in   1        single clock; all state on rising edge
//   rst            in   1        synchronous, active-high reset
//   in_valid       in   1        in_data carries a byte this cycle
//   in_ready       out  1        block accepts a byte this cycle
//   in_data        in   8        input byte (raw ASCII / 8-bit code)
//   out_valid      out  1        out_data holds a converted byte
//   out_ready      in   1        sink accepts out_data this cycle
//   out_data       out  8        converted byte
//   out_converted  out  1        1 = out_data was changed (lowercase input)
//   conv_count     out  COUNT_W  number of bytes converted since reset
// BEHAVIOUR
//   - Reset: out_valid=0, out_data=0x00, out_converted=0, conv_count=0.
//     rst has priority over every other event; an in-flight byte is dropped.
//   - Conversion (combinational, pre-register):
//     is_lower = (in_data >= 8'h61) && (in_data <= 8'h7A)
//     conv     = is_lower ? (in_data & 8'hDF) : in_data
//     Bit 5 is cleared only for is_lower. Nothing else is modified.
//     0x60 '`', 0x7B '{', 0x41..0x5A, and all bytes >= 0x80 pass unchanged.
//   - Handshake: in_ready = !out_valid || out_ready (combinational).
//     A transfer happens when in_valid && in_ready. On a transfer, on the
//     next edge: out_data<=conv, out_converted<=is_lower, out_valid<=1.
//   - When out_valid && out_ready and there is no new transfer: out_valid<=0.
//     out_data and out_converted hold their last value.
//   - A simultaneous output drain and input transfer gives back-to-back
//     throughput: 1 byte/cycle, latency exactly 1 cycle.
//   - Stall: while out_valid && !out_ready, out_data and out_converted are
//     held stable and in_ready=0.
//   - conv_count increments by 1 on each input transfer with is_lower=1.
//     It saturates at all-ones and does not wrap.
// STRUCTURE
//   - Shared package: constants ASCII_LOWER_MIN=8'h61, ASCII_LOWER_MAX=8'h7A,
//     CASE_BIT=5.
//   - Sub-module to_upper_core: purely combinational
//     (in[7:0] -> out[7:0], is_lower). It is instantiated once, ahead of
//     the output register. The top level holds the handshake register and
//     the counter.
// TESTING
//   - Reset, then in=97 'a' -> out_data=65 'A', out_converted=1,
//     conv_count=1.
//   - Boundaries: 122 'z' -> 90 'Z'; 96 '`' -> 96; 123 '{' -> 123;
//     65 'A' -> 65 (converted=0).
//   - Pass-through: 40, 48, 58, 124, 20, 127, 131, 146, 148, 183, 207, 235
//     -> identical, out_converted=0, conv_count unchanged.
//   - Streaming: hold out_ready=1 and send 72,109,71 on consecutive cycles
//     -> 72,77,71 on consecutive cycles, 1-cycle latency, conv_count +1.
//   - Backpressure: out_ready=0 with byte 109 held -> in_ready=0, out_data
//     stays 77. Release -> drains, then next byte is accepted.
//   - Assert rst mid-stream -> next cycle out_valid=0, out_data=0,
//     conv_count=0. Counter saturation checked with COUNT_W=2
//     (5 lowercase bytes -> 3).

Source files
------------

// File: rtl/to_upper_pkg.sv
// Shared constants and types for the to_upper byte case converter.
//   BYTE_W           width of one character code
//   ASCII_LOWER_MIN  first lowercase letter 'a'
//   ASCII_LOWER_MAX  last lowercase letter 'z'
//   CASE_BIT         bit that separates upper/lower case in ASCII letters
//   beat_t           one registered output beat (byte + converted flag)
package to_upper_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t       ASCII_LOWER_MIN = 8'h61;
    localparam byte_t       ASCII_LOWER_MAX = 8'h7A;
    localparam int unsigned CASE_BIT        = 5;

    // Clearing this bit turns 'a'..'z' into 'A'..'Z'.
    localparam byte_t CASE_MASK = ~(BYTE_W'(1) << CASE_BIT);

    typedef struct packed {
        byte_t data;
        logic  converted;
    } beat_t;

    // True only for the 26 lowercase ASCII letters.
    function automatic logic is_lower_byte(input byte_t b);
        return (b >= ASCII_LOWER_MIN) && (b <= ASCII_LOWER_MAX);
    endfunction

endpackage

// File: rtl/to_upper_core.sv
// Combinational case mapping for one byte.
//   in_byte   in   8   raw input code
//   out_byte  out  8   uppercase form for 'a'..'z', otherwise in_byte
//   is_lower  out  1   in_byte is a lowercase ASCII letter
module to_upper_core
    import to_upper_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] out_byte,
    output logic              is_lower
);

    // Only lowercase letters lose the case bit; every other code passes as is.
    always_comb begin
        is_lower = is_lower_byte(in_byte);
        out_byte = is_lower ? (in_byte & CASE_MASK) : in_byte;
    end

endmodule

// File: rtl/to_upper.sv
// Streaming ASCII lowercase-to-uppercase converter with a one-deep output
// register on a valid/ready handshake and a saturating conversion counter.
//   clk            in   1        rising-edge clock
//   rst            in   1        synchronous active-high reset
//   in_valid       in   1        in_data holds a byte
//   in_ready       out  1        byte accepted this cycle (combinational)
//   in_data        in   8        input byte
//   out_valid      out  1        out_data holds a byte
//   out_ready      in   1        sink takes out_data this cycle
//   out_data       out  8        converted byte
//   out_converted  out  1        out_data differs from its input byte
//   conv_count     out  COUNT_W  bytes converted since reset, saturating
module to_upper
    import to_upper_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BYTE_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BYTE_W-1:0]  out_data,
    output logic               out_converted,
    output logic [COUNT_W-1:0] conv_count
);

    byte_t conv;
    logic  is_lower;
    logic  transfer;
    beat_t beat_q;

    to_upper_core u_core (
        .in_byte  (in_data),
        .out_byte (conv),
        .is_lower (is_lower)
    );

    // Register is free when empty or being drained in this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign transfer = in_valid && in_ready;

    // Output register: load on transfer, empty on drain, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            beat_q    <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            beat_q    <= '{data: conv, converted: is_lower};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Conversion statistic, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_count <= '0;
        end else if (transfer && is_lower && (conv_count != '1)) begin
            conv_count <= conv_count + COUNT_W'(1);
        end
    end

    assign out_data      = beat_q.data;
    assign out_converted = beat_q.converted;

endmodule

// File: tb/tb_to_upper.sv
module tb_to_upper;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_converted;
    logic [15:0] conv_count;

    // Second instance with a tiny counter, shares all stimulus.
    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic        s_out_converted;
    logic [1:0]  s_conv_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_valid;
    int m_data;
    bit m_conv;
    int n_conv;

    to_upper #(.COUNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_converted(out_converted), .conv_count(conv_count)
    );

    to_upper #(.COUNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_converted(s_out_converted), .conv_count(s_conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_lower(input int b);
        return (b >= 97) && (b <= 122);
    endfunction

    function automatic int ref_upper(input int b);
        return ref_lower(b) ? b - 32 : b;
    endfunction

    // One clock: drive, check ready, advance model, check registered outputs.
    task automatic cycle(input bit v, input int d, input bit ordy, input bit r);
        bit exp_ready;
        bit xfer;
        rst       = r;
        in_valid  = v;
        in_data   = 8'(d);
        out_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("sat_in_ready", 32'(s_in_ready), 32'(exp_ready));
        xfer = v && exp_ready;
        if (r) begin
            m_valid = 0; m_data = 0; m_conv = 0; n_conv = 0;
        end else if (xfer) begin
            m_valid = 1;
            m_data  = ref_upper(d);
            m_conv  = ref_lower(d);
            if (m_conv) n_conv++;
        end else if (ordy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_converted", 32'(out_converted), 32'(m_conv));
        check("conv_count", 32'(conv_count), 32'(n_conv > 65535 ? 65535 : n_conv));
        check("sat_count", 32'(s_conv_count), 32'(n_conv > 3 ? 3 : n_conv));
        check("sat_out_data", 32'(s_out_data), 32'(m_data));
        check("sat_out_valid", 32'(s_out_valid), 32'(m_valid));
        check("sat_out_converted", 32'(s_out_converted), 32'(m_conv));
    endtask

    initial begin
        int pass_list [12] = '{40, 48, 58, 124, 20, 127, 131, 146, 148, 183, 207, 235};
        int bnd_list  [4]  = '{122, 96, 123, 65};
        int stream    [3]  = '{72, 109, 71};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        m_valid = 0; m_data = 0; m_conv = 0; n_conv = 0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(0, 0, 0, 1);
        cycle(1, 97, 1, 1);

        // First conversion 'a' -> 'A'
        cycle(1, 97, 1, 0);

        // Boundary codes around the lowercase range
        foreach (bnd_list[i]) cycle(1, bnd_list[i], 1, 0);

        // Pass-through codes
        foreach (pass_list[i]) cycle(1, pass_list[i], 1, 0);
        cycle(0, 0, 1, 0);

        // Back-to-back streaming
        foreach (stream[i]) cycle(1, stream[i], 1, 0);
        cycle(0, 0, 1, 0);

        // Backpressure: 77 stalls in the register while 71 waits
        cycle(1, 72, 1, 0);
        cycle(1, 109, 1, 0);
        cycle(1, 71, 0, 0);
        cycle(1, 71, 0, 0);
        cycle(1, 71, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 71, 1, 0);

        // Reset mid-stream drops the held byte
        cycle(1, 98, 0, 0);
        cycle(1, 99, 0, 1);
        cycle(0, 0, 1, 0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) cycle(1, 97 + i, 1, 0);
        cycle(1, 65, 1, 0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            int  d;
            bit  v, ordy, r;
            d    = ($urandom_range(0, 1) == 0) ? $urandom_range(96, 123) : $urandom_range(0, 255);
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            r    = ($urandom_range(0, 60) == 0);
            cycle(v, d, ordy, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
